// File: rtl/intirvx_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : intirvx_wb_arbiter                                            |
// | Brief    : round-robin share of the register-file write port across      |
// |            NREQ calculation units, one holding buffer per unit.          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module intirvx_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*5-1:0]    req_adr,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [XLEN+4:0]      wb,
  output logic                 wb_valid,
  output logic [NREQ-1:0]      wb_src,
  output logic [31:0]          wb_count
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

  logic [NREQ-1:0]  buf_v_q, buf_v_d;
  logic [4:0]       buf_adr_q  [NREQ];
  logic [4:0]       buf_adr_d  [NREQ];
  logic [XLEN-1:0]  buf_data_q [NREQ];
  logic [XLEN-1:0]  buf_data_d [NREQ];
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [XLEN+4:0]  wb_q, wb_d;
  logic             wb_valid_q, wb_valid_d;
  logic [NREQ-1:0]  wb_src_q, wb_src_d;
  logic [31:0]      wb_count_q, wb_count_d;

  logic [NREQ-1:0]  grant;
  logic [PTR_W-1:0] gidx;
  logic             found;

  // Round-robin search starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    logic [PTR_W:0] cand;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NREQ)) begin
        cand = cand - (PTR_W+1)'(NREQ);
      end
      if (!found && buf_v_q[cand[PTR_W-1:0]]) begin
        grant[cand[PTR_W-1:0]] = 1'b1;
        gidx  = cand[PTR_W-1:0];
        found = 1'b1;
      end
    end
  end

  // A granted buffer frees up in the same cycle, so a unit can refill it back-to-back.
  assign req_ready = ~buf_v_q | grant;

  always_comb begin
    buf_v_d    = buf_v_q;
    buf_adr_d  = buf_adr_q;
    buf_data_d = buf_data_q;
    rr_ptr_d   = rr_ptr_q;
    wb_d       = wb_q;
    wb_valid_d = found;
    wb_src_d   = grant;
    wb_count_d = wb_count_q + {31'd0, found};

    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        buf_v_d[i]    = 1'b1;
        buf_adr_d[i]  = req_adr[5*i +: 5];
        buf_data_d[i] = req_data[XLEN*i +: XLEN];
      end else if (grant[i]) begin
        buf_v_d[i] = 1'b0;
      end
    end

    if (found) begin
      wb_d     = {buf_adr_q[gidx], buf_data_q[gidx]};
      rr_ptr_d = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_v_q    <= '0;
      rr_ptr_q   <= '0;
      wb_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_src_q   <= '0;
      wb_count_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        buf_adr_q[i]  <= '0;
        buf_data_q[i] <= '0;
      end
    end else begin
      buf_v_q    <= buf_v_d;
      rr_ptr_q   <= rr_ptr_d;
      wb_q       <= wb_d;
      wb_valid_q <= wb_valid_d;
      wb_src_q   <= wb_src_d;
      wb_count_q <= wb_count_d;
      for (int i = 0; i < NREQ; i++) begin
        buf_adr_q[i]  <= buf_adr_d[i];
        buf_data_q[i] <= buf_data_d[i];
      end
    end
  end

  assign wb       = wb_q;
  assign wb_valid = wb_valid_q;
  assign wb_src   = wb_src_q;
  assign wb_count = wb_count_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  a_src_matches:  assert property (@(posedge clk) disable iff (!rst_n) wb_valid_q == (|wb_src_q));
  a_no_overwrite: assert property (@(posedge clk) disable iff (!rst_n)
                                   (buf_v_q & req_ready & ~grant) == '0);

endmodule
`default_nettype wire

// File: tb/tb_intirvx_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_intirvx_wb_arbiter                                         |
// | Brief    : self-checking bench, queue-based reference model.             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_intirvx_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*5-1:0]    req_adr;
  logic [NREQ*XLEN-1:0] req_data;
  logic [XLEN+4:0]      wb;
  logic                 wb_valid;
  logic [NREQ-1:0]      wb_src;
  logic [31:0]          wb_count;

  intirvx_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_adr  (req_adr),
    .req_data (req_data),
    .wb       (wb),
    .wb_valid (wb_valid),
    .wb_src   (wb_src),
    .wb_count (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each unit owns a queue of pending {adr,data} results.
  logic [XLEN+4:0] mq [NREQ][$];
  int              mptr;
  logic            m_valid;
  logic [XLEN+4:0] m_wb;
  logic [NREQ-1:0] m_src;
  logic [31:0]     m_count;
  logic [NREQ-1:0] last_acc;

  function automatic int m_grant();
    for (int k = 0; k < NREQ; k++) begin
      if (mq[(mptr + k) % NREQ].size() != 0) return (mptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] m_ready();
    logic [NREQ-1:0] r;
    int g;
    g = m_grant();
    for (int i = 0; i < NREQ; i++) r[i] = (mq[i].size() == 0) || (g == i);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) mq[i].delete();
    mptr = 0; m_valid = 1'b0; m_wb = '0; m_src = '0; m_count = '0; last_acc = '0;
  endtask

  // Advance one clock edge in both DUT and model; outputs settle 1 time unit later.
  task automatic tick();
    int g;
    logic [NREQ-1:0] rdy;
    g   = m_grant();
    rdy = m_ready();
    @(posedge clk);
    if (rst_n) begin
      if (g >= 0) begin
        m_wb    = mq[g].pop_front();
        m_valid = 1'b1;
        m_src   = NREQ'(1) << g;
        m_count = m_count + 1;
        mptr    = (g + 1) % NREQ;
      end else begin
        m_valid = 1'b0;
        m_src   = '0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && rdy[i]) mq[i].push_back({req_adr[5*i +: 5], req_data[XLEN*i +: XLEN]});
      end
      last_acc = req_valid & rdy;
    end
    #1;
  endtask

  // Random stimulus on enabled units, holding any offer not yet accepted.
  task automatic drive_rand(input logic [NREQ-1:0] en, input int pct);
    for (int i = 0; i < NREQ; i++) begin
      if (!(req_valid[i] && !last_acc[i])) begin
        req_valid[i]             = en[i] && ($urandom_range(99) < pct);
        req_adr[5*i +: 5]        = 5'($urandom);
        req_data[XLEN*i +: XLEN] = $urandom;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; req_adr = '0; req_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL reset_ready got %b want 111", req_ready); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
    checks++; if (wb_count !== 32'd0) begin errors++; $display("FAIL reset_wb_count got %0d want 0", wb_count); end
    checks++; if (wb !== '0 || wb_src !== '0) begin errors++; $display("FAIL reset_wb got %h/%b want 0/0", wb, wb_src); end
    rst_n = 1'b1; req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_idle cycle %0d wb_valid got %b want 0", c, wb_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_single();
    req_valid = 3'b010; req_adr[9:5] = 5'd5; req_data[63:32] = 32'hDEADBEEF;
    checks++; if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", req_ready[1]); end
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL single_cycle1 wb_valid got %b want 0", wb_valid); end
    @(negedge clk); req_valid = '0;
    tick();
    checks++; if (wb_valid !== 1'b1 || wb !== {5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL single_wb got v=%b %h want v=1 %h", wb_valid, wb, {5'd5, 32'hDEADBEEF}); end
    checks++; if (wb_src !== 3'b010 || wb_count !== 32'd1) begin
      errors++; $display("FAIL single_src_count got %b/%0d want 010/1", wb_src, wb_count); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [4:0] want_adr [6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
    int n;
    apply_reset();
    req_valid = 3'b111; req_adr = {5'd3, 5'd2, 5'd1};
    req_data = {32'hC0C0_0003, 32'hB0B0_0002, 32'hA0A0_0001};
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 1) begin
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL contention_stall got %b want 001", req_ready); end
      end
      checks++; if (req_ready !== m_ready()) begin errors++; $display("FAIL contention_ready c%0d got %b want %b", c, req_ready, m_ready()); end
      tick();
      checks++; if (wb_valid !== m_valid || wb_src !== m_src || (m_valid && wb !== m_wb)) begin
        errors++; $display("FAIL contention_wb c%0d got %b %b %h want %b %b %h", c, wb_valid, wb_src, wb, m_valid, m_src, m_wb); end
      if (wb_valid && n < 6) begin
        checks++; if (wb[XLEN+4:XLEN] !== want_adr[n] || c != n + 1) begin
          errors++; $display("FAIL contention_order c%0d got adr %0d want adr %0d at c%0d", c, wb[XLEN+4:XLEN], want_adr[n], n + 1); end
        n++;
      end
      @(negedge clk);
      if (c == 0) begin
        req_adr = {5'd6, 5'd5, 5'd4};
        req_data = {32'hC0C0_0006, 32'hB0B0_0005, 32'hA0A0_0004};
      end
      for (int i = 0; i < NREQ; i++) if (c >= 1 && last_acc[i]) req_valid[i] = 1'b0;
    end
    checks++; if (n != 6 || wb_count !== 32'd6) begin errors++; $display("FAIL contention_total got %0d/%0d want 6/6", n, wb_count); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    apply_reset();
    pulses = 0;
    for (int c = 0; c < 11; c++) begin
      req_valid = (c < 8) ? 3'b001 : 3'b000;
      req_adr[4:0] = 5'(c + 8); req_data[31:0] = 32'h1000 + c;
      if (c < 8) begin
        checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready c%0d got %b want 1", c, req_ready[0]); end
      end
      tick();
      if (c >= 1 && c <= 8) begin
        checks++; if (wb_valid !== 1'b1 || wb !== {5'(pulses + 8), 32'h1000 + pulses}) begin
          errors++; $display("FAIL b2b_wb c%0d got v=%b %h want v=1 %h", c, wb_valid, wb, {5'(pulses + 8), 32'h1000 + pulses}); end
        pulses++;
      end
      @(negedge clk);
    end
    checks++; if (wb_count !== 32'd8 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_count got %0d v=%b want 8 v=0", wb_count, wb_valid); end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] prev;
    int wait_n;
    apply_reset();
    req_valid = '0; prev = '0;
    for (int c = 0; c < 12; c++) begin
      drive_rand(3'b101, 100);
      tick();
      checks++; if (wb_valid !== m_valid || wb_src !== m_src || (m_valid && wb !== m_wb)) begin
        errors++; $display("FAIL fair_model c%0d got %b %b %h want %b %b %h", c, wb_valid, wb_src, wb, m_valid, m_src, m_wb); end
      if (c >= 2) begin
        checks++; if (!wb_valid || wb_src === prev) begin
          errors++; $display("FAIL fair_alternate c%0d got src %b prev %b want alternate", c, wb_src, prev); end
      end
      prev = wb_src;
      @(negedge clk);
    end
    // Unit 1 joins the two saturating units.
    req_valid[1] = 1'b1; req_adr[9:5] = 5'd17; req_data[63:32] = 32'h5EED_0001;
    wait_n = 0;
    while (!last_acc[1] && wait_n < 6) begin
      drive_rand(3'b101, 100);
      tick(); wait_n++;
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    wait_n = 0;
    while (wait_n < 10) begin
      drive_rand(3'b101, 100);
      tick(); wait_n++;
      if (wb_src === 3'b010) break;
      @(negedge clk);
    end
    checks++; if (wb_src !== 3'b010 || wait_n > NREQ + 1 || wb !== {5'd17, 32'h5EED_0001}) begin
      errors++; $display("FAIL fair_join got src %b after %0d cycles want 010 within %0d", wb_src, wait_n, NREQ + 1); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      drive_rand(3'b111, 55);
      checks++; if (req_ready !== m_ready()) begin
        errors++; bad++; if (bad < 5) $display("FAIL rand_ready c%0d got %b want %b", c, req_ready, m_ready()); end
      tick();
      checks++; if (wb_valid !== m_valid || wb_src !== m_src || (m_valid && wb !== m_wb) || wb_count !== m_count) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL rand_wb c%0d got %b %b %h %0d want %b %b %h %0d", c, wb_valid, wb_src, wb, wb_count, m_valid, m_src, m_wb, m_count);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    req_valid = 3'b111; req_adr = {5'd9, 5'd10, 5'd11}; req_data = '1;
    tick();
    #2;
    rst_n = 1'b0; req_valid = '0;
    model_reset();
    #1;
    checks++; if (wb_valid !== 1'b0 || wb_count !== 32'd0 || wb_src !== '0) begin
      errors++; $display("FAIL midreset_async got v=%b cnt=%0d src=%b want 0/0/0", wb_valid, wb_count, wb_src); end
    checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL midreset_ready got %b want 111", req_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (wb_valid !== 1'b0 || wb_count !== 32'd0) begin
        errors++; $display("FAIL midreset_dropped c%0d got v=%b cnt=%0d want 0/0", c, wb_valid, wb_count); end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    req_valid = '0;
    force dut.wb_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count_q;
    m_count = 32'hFFFF_FFFF;
    tick();
    checks++; if (wb_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_hold got %h want ffffffff", wb_count); end
    @(negedge clk);
    req_valid = 3'b100; req_adr[14:10] = 5'd0; req_data[95:64] = 32'h0BAD_F00D;
    tick();
    @(negedge clk); req_valid = '0;
    tick();
    checks++; if (wb_valid !== 1'b1 || wb_count !== 32'd0 || wb !== {5'd0, 32'h0BAD_F00D}) begin
      errors++; $display("FAIL wrap_count got v=%b cnt=%h wb=%h want v=1 cnt=0 wb=%h", wb_valid, wb_count, wb, {5'd0, 32'h0BAD_F00D}); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_fairness();
    test_random();
    test_mid_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
